// File: rtl/rot_imm_encoder.sv
// Multi-cycle search for a {Rot4, Imm8} rotate-right immediate encoding of a 32-bit constant.
// Optional ROT_IMM_ENC_INVERT_EN: after the direct search fails, also search ~Value (Inv=1).
module rot_imm_encoder #(
  parameter int CANDS_PER_CYCLE = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic [31:0] Value,
  output logic        Busy,
  output logic        Done,
  output logic        Found,
  output logic [3:0]  Rot4,
  output logic [7:0]  Imm8,
  output logic        Inv
);

  localparam int G = 16 / CANDS_PER_CYCLE;
`ifdef ROT_IMM_ENC_INVERT_EN
  localparam int NGRP = 2 * G;
`else
  localparam int NGRP = G;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] val_q, val_d;
  logic [4:0]  grp_q, grp_d;
  logic        found_q, found_d;
  logic [3:0]  rot_q, rot_d;
  logic [7:0]  imm_q, imm_d;

  logic        accept;
  logic        last;
  logic        phase;
  logic [31:0] src;
  logic        hit;
  logic [3:0]  hit_rot;
  logic [7:0]  hit_imm;

  function automatic logic [31:0] rol2(input logic [31:0] v,
                                       input logic [3:0] r);
    logic [63:0] w;
    w = {v, v} << {r, 1'b0};
    return w[63:32];
  endfunction

  // A request is taken whenever no search is in flight.
  assign accept = Start && (state_q != S_SEARCH);
  assign last   = (grp_q == 5'(NGRP - 1));
  // Groups past the first G cover the inverted constant.
  assign phase  = (int'(grp_q) >= G);
  assign src    = phase ? ~val_q : val_q;

  // Test every rotation of the current group; lowest match wins.
  always_comb begin
    logic [3:0]  r;
    logic [31:0] t;
    int          base;
    hit     = 1'b0;
    hit_rot = 4'd0;
    hit_imm = 8'd0;
    r       = 4'd0;
    t       = 32'd0;
    base    = (int'(grp_q) % G) * CANDS_PER_CYCLE;
    for (int i = 0; i < CANDS_PER_CYCLE; i++) begin
      r = 4'(base + i);
      t = rol2(src, r);
      if (!hit && t[31:8] == 24'd0) begin
        hit     = 1'b1;
        hit_rot = r;
        hit_imm = t[7:0];
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (Start) state_d = S_SEARCH;
      S_SEARCH: if (hit || last) state_d = S_DONE;
      S_DONE:   state_d = Start ? S_SEARCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and result registers.
  always_comb begin
    Busy  = (state_q == S_SEARCH);
    Done  = (state_q == S_DONE);
    Found = found_q;
    Rot4  = rot_q;
    Imm8  = imm_q;
  end

  // Datapath next-state: latch on accept, advance or capture while searching.
  always_comb begin
    val_d   = val_q;
    grp_d   = grp_q;
    found_d = found_q;
    rot_d   = rot_q;
    imm_d   = imm_q;
    if (accept) begin
      val_d   = Value;
      grp_d   = 5'd0;
      found_d = 1'b0;
      rot_d   = 4'd0;
      imm_d   = 8'd0;
    end else if (state_q == S_SEARCH) begin
      if (hit) begin
        found_d = 1'b1;
        rot_d   = hit_rot;
        imm_d   = hit_imm;
      end else if (!last) begin
        grp_d = grp_q + 5'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      val_q   <= 32'd0;
      grp_q   <= 5'd0;
      found_q <= 1'b0;
      rot_q   <= 4'd0;
      imm_q   <= 8'd0;
    end else begin
      val_q   <= val_d;
      grp_q   <= grp_d;
      found_q <= found_d;
      rot_q   <= rot_d;
      imm_q   <= imm_d;
    end
  end

`ifdef ROT_IMM_ENC_INVERT_EN
  logic inv_q, inv_d;

  // Inverted-form flag follows the same capture rules as the result.
  always_comb begin
    inv_d = inv_q;
    if (accept) inv_d = 1'b0;
    else if (state_q == S_SEARCH && hit) inv_d = phase;
  end

  // Inverted-form flag register.
  always_ff @(posedge CLK) begin
    if (RESET) inv_q <= 1'b0;
    else       inv_q <= inv_d;
  end

  assign Inv = inv_q;
`else
  assign Inv = 1'b0;
`endif

endmodule

// File: tb/tb_rot_imm_encoder.sv
// Scoreboard bench for rot_imm_encoder (C=1): directed constants, random
// encodable values, mid-search Start, back-to-back, and reset abort.
module tb_rot_imm_encoder;

  localparam int C = 1;
  localparam int G = 16 / C;
`ifdef ROT_IMM_ENC_INVERT_EN
  localparam int NGRP = 2 * G;
`else
  localparam int NGRP = G;
`endif

  typedef struct {
    logic       found;
    logic [3:0] rot;
    logic [7:0] imm;
    logic       inv;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = 32'd0;
  logic        busy, done, found, inv;
  logic [3:0]  rot4;
  logic [7:0]  imm8;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rot_imm_encoder #(.CANDS_PER_CYCLE(C)) dut (
    .CLK(clk), .RESET(rst), .Start(start), .Value(value),
    .Busy(busy), .Done(done), .Found(found),
    .Rot4(rot4), .Imm8(imm8), .Inv(inv)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] v, input int s);
    if (s == 0) return v;
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic exp_t mk(input logic f, input int r, input int im,
                              input logic iv, input int lat);
    exp_t e;
    e.found = f; e.rot = 4'(r); e.imm = 8'(im); e.inv = iv; e.lat = lat;
    return e;
  endfunction

  // Reference search: direct rotations first, then inverted if enabled.
  function automatic exp_t model(input logic [31:0] v);
    logic [31:0] s, t;
    int nph;
`ifdef ROT_IMM_ENC_INVERT_EN
    nph = 2;
`else
    nph = 1;
`endif
    for (int p = 0; p < nph; p++) begin
      s = (p == 1) ? ~v : v;
      for (int r = 0; r < 16; r++) begin
        t = rol(s, 2 * r);
        if (t[31:8] == 24'd0)
          return mk(1'b1, r, int'(t[7:0]), p == 1, p * G + r / C + 1);
      end
    end
    return mk(1'b0, 0, 0, 1'b0, NGRP);
  endfunction

  // Drive Start at a negedge; returns at the negedge after the accept edge.
  task automatic start_req(input logic [31:0] v, input exp_t e,
                           input bit push);
    start = 1'b1;
    value = v;
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    value = $urandom;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("cleared_after_start", {done, found, inv, rot4, imm8}, 32'd0);
  endtask

  task automatic wait_done();
    exp_t e;
    int n;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("found", 32'(found), 32'(e.found));
    chk("rot4", 32'(rot4), 32'(e.rot));
    chk("imm8", 32'(imm8), 32'(e.imm));
    chk("inv", 32'(inv), 32'(e.inv));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  logic [31:0] tv[$];
  exp_t        te[$];
  logic [31:0] v;
  bit          seen;

  initial begin
    tv.push_back(32'h000000FF); te.push_back(mk(1, 0, 8'hFF, 0, 1));
    tv.push_back(32'hFF000000); te.push_back(mk(1, 4, 8'hFF, 0, 5));
    tv.push_back(32'hC000003F); te.push_back(mk(1, 1, 8'hFF, 0, 2));
    tv.push_back(32'h000003FC); te.push_back(mk(1, 15, 8'hFF, 0, 16));
    tv.push_back(32'h00000000); te.push_back(mk(1, 0, 8'h00, 0, 1));
    tv.push_back(32'h00AB0000); te.push_back(mk(1, 8, 8'hAB, 0, 9));
`ifdef ROT_IMM_ENC_INVERT_EN
    tv.push_back(32'h00000101); te.push_back(mk(0, 0, 0, 0, 32));
    tv.push_back(32'hFFFFFF00); te.push_back(mk(1, 0, 8'hFF, 1, 17));
`else
    tv.push_back(32'h00000101); te.push_back(mk(0, 0, 0, 0, 16));
    tv.push_back(32'hFFFFFF00); te.push_back(mk(0, 0, 0, 0, 16));
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, found, inv, rot4, imm8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {busy, done, found, inv, rot4, imm8}, 32'd0);

    // Directed constants, with an idle cycle between requests.
    foreach (tv[i]) begin
      start_req(tv[i], te[i], 1'b1);
      wait_done();
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
    end

    // Random encodable values, some with a stray bit set.
    for (int i = 0; i < 12; i++) begin
      v = rol({24'd0, 8'($urandom)}, 32 - 2 * $urandom_range(0, 15));
      if (i % 3 == 2) v = v | (32'd1 << $urandom_range(0, 31));
      start_req(v, model(v), 1'b1);
      wait_done();
    end

    // Start while busy is ignored; the first request's result returns.
    start_req(32'h00000101, te[6], 1'b1);
    start = 1'b1;
    value = 32'h000000FF;
    wait_done();

    // Back-to-back: Start during DONE begins a new search immediately.
    start_req(32'hFF000000, te[1], 1'b1);
    wait_done();
    start_req(32'hC000003F, te[2], 1'b1);
    wait_done();
    start_req(32'h000003FC, te[3], 1'b1);
    wait_done();

    // Reset at edge 3 of a long search aborts with no Done.
    @(negedge clk);
    start_req(32'h00000101, te[6], 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_outputs", {busy, done, found, inv, rot4, imm8}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("no_done_after_abort", 32'(seen), 32'd0);

    // Reset and Start together: request dropped.
    rst = 1'b1;
    start = 1'b1;
    value = 32'h000000FF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_wins_busy", {busy, done}, 32'd0);

    start_req(32'hFF000000, te[1], 1'b1);
    wait_done();
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
